// File: rtl/fc_pkg.sv
// Shared defaults and FSM state type for the fully-connected layer sequencer.
package fc_pkg;
    localparam int FC_IN_NUM  = 256;
    localparam int FC_OUT_NUM = 32;
    localparam int FC_DATA_W  = 8;
    localparam int FEAT_W     = 8;
    localparam int ACC_W      = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT
    } fc_state_t;
endpackage

// File: rtl/fc_layer_ctrl_if.sv
// Valid/ready result port between the FC sequencer and the classifier stage.
interface fc_layer_ctrl_if #(
    parameter int OIDX_W = $clog2(fc_pkg::FC_OUT_NUM),
    parameter int ACC_W  = fc_pkg::ACC_W
) ();
    logic                    out_valid;
    logic                    out_ready;
    logic [OIDX_W-1:0]       out_idx;
    logic signed [ACC_W-1:0] out_data;

    modport master (output out_valid, out_idx, out_data, input out_ready);
    modport slave  (input out_valid, out_idx, out_data, output out_ready);
endinterface

// File: rtl/fc_mac.sv
// Signed multiply-accumulate with synchronous clear; the sum wraps modulo 2^ACC_W.
module fc_mac #(
    parameter int FC_DATA_W = fc_pkg::FC_DATA_W,
    parameter int FEAT_W    = fc_pkg::FEAT_W,
    parameter int ACC_W     = fc_pkg::ACC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [FC_DATA_W-1:0] weight,
    input  logic signed [FEAT_W-1:0]    feat,
    output logic signed [ACC_W-1:0]     sum_nxt
);
    localparam int PROD_W = FC_DATA_W + FEAT_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;

    assign prod    = weight * feat;
    // sum_nxt lets the sequencer capture the final sum on the same edge as the last product
    assign sum_nxt = acc_q + ACC_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_q <= '0;
        else if (clr)
            acc_q <= '0;
        else if (en)
            acc_q <= sum_nxt;
    end
endmodule

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer: streams weight ROM and feature buffer through one MAC
// and presents each neuron's sum on a valid/ready port.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FETCH | issuing weight/feature reads for neuron o
// S_DRAIN | waiting for the last product to reach the accumulator
// S_OUT   | holding neuron o's sum until the consumer accepts it
module fc_layer_ctrl #(
    parameter int IN_NUM    = fc_pkg::FC_IN_NUM,
    parameter int OUT_NUM   = fc_pkg::FC_OUT_NUM,
    parameter int FC_DATA_W = fc_pkg::FC_DATA_W,
    parameter int FEAT_W    = fc_pkg::FEAT_W,
    parameter int ACC_W     = fc_pkg::ACC_W,
    parameter int ADDR_W    = $clog2(IN_NUM * OUT_NUM),
    parameter int FADDR_W   = $clog2(IN_NUM),
    parameter int OIDX_W    = $clog2(OUT_NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           rom_raddr,
    input  logic signed [FC_DATA_W-1:0] rom_dout,
    output logic [FADDR_W-1:0]          feat_raddr,
    input  logic signed [FEAT_W-1:0]    feat_din,
    fc_layer_ctrl_if.master             out_bus
);
    fc_pkg::fc_state_t state_q, state_d;
    logic [OIDX_W-1:0] o_q;
    logic iss_v_q, d_v_q;
    logic last_issue, last_neuron, out_fire, acc_clr;
    logic signed [ACC_W-1:0] sum_nxt;

    assign last_issue  = (feat_raddr == FADDR_W'(IN_NUM - 1));
    assign last_neuron = (o_q == OIDX_W'(OUT_NUM - 1));
    assign out_fire    = out_bus.out_valid && out_bus.out_ready;
    assign acc_clr     = (state_d == fc_pkg::S_FETCH) && (state_q != fc_pkg::S_FETCH);

    fc_mac #(.FC_DATA_W(FC_DATA_W), .FEAT_W(FEAT_W), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (d_v_q),
        .weight (rom_dout),
        .feat   (feat_din),
        .sum_nxt(sum_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= fc_pkg::S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // done is still high in the first IDLE cycle; a start there is dropped
            fc_pkg::S_IDLE:  if (start && !done) state_d = fc_pkg::S_FETCH;
            fc_pkg::S_FETCH: if (last_issue) state_d = fc_pkg::S_DRAIN;
            fc_pkg::S_DRAIN: if (d_v_q && !iss_v_q) state_d = fc_pkg::S_OUT;
            fc_pkg::S_OUT:   if (out_fire) state_d = last_neuron ? fc_pkg::S_IDLE : fc_pkg::S_FETCH;
            default:         state_d = fc_pkg::S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy              <= 1'b0;
            done              <= 1'b0;
            o_q               <= '0;
            iss_v_q           <= 1'b0;
            d_v_q             <= 1'b0;
            rom_raddr         <= '0;
            feat_raddr        <= '0;
            out_bus.out_valid <= 1'b0;
            out_bus.out_idx   <= '0;
            out_bus.out_data  <= '0;
        end else begin
            d_v_q <= iss_v_q;
            done  <= 1'b0;
            case (state_q)
                fc_pkg::S_IDLE: begin
                    if (state_d == fc_pkg::S_FETCH) begin
                        busy       <= 1'b1;
                        o_q        <= '0;
                        rom_raddr  <= '0;
                        feat_raddr <= '0;
                        iss_v_q    <= 1'b1;
                    end
                end
                fc_pkg::S_FETCH: begin
                    if (last_issue) begin
                        iss_v_q <= 1'b0;
                    end else begin
                        rom_raddr  <= rom_raddr + ADDR_W'(1);
                        feat_raddr <= feat_raddr + FADDR_W'(1);
                    end
                end
                fc_pkg::S_DRAIN: begin
                    if (d_v_q && !iss_v_q) begin
                        out_bus.out_valid <= 1'b1;
                        out_bus.out_data  <= sum_nxt;
                        out_bus.out_idx   <= o_q;
                    end
                end
                fc_pkg::S_OUT: begin
                    if (out_fire) begin
                        out_bus.out_valid <= 1'b0;
                        if (last_neuron) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            // next row starts on the handshake edge, no idle bubble
                            o_q        <= o_q + OIDX_W'(1);
                            rom_raddr  <= rom_raddr + ADDR_W'(1);
                            feat_raddr <= '0;
                            iss_v_q    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
